tx_beam_pulser: RTL

Per-channel transmit beamforming pulser, the transmit-side counterpart of the per-channel receive beamformer channel. On a transmit trigger it looks up the channel's focusing delay for the selected beam line from an on-chip delay LUT, waits that many clock cycles, then drives a bipolar pulse burst to the channel's front-end pulser. It also generates `tx_en`, the transmit window that gates the receive chain's coarse-delay input valid.

---
 rtl/tx_beam_pulser.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/tx_beam_pulser.sv
// tx_beam_pulser: per-channel transmit beamforming pulser.
// A trigger looks up the focusing delay for the selected beam line and waits
// that many cycles. It then drives a bipolar burst of num_cyc full cycles,
// each half lasting max(half_per,1) clocks.
// Optional feature macro: TX_DAMP_EN adds a post-burst clamp (DAMP state, tx_clamp).
module tx_beam_pulser #(
    parameter int unsigned ADDR_WD  = 7,
    parameter int unsigned DLY_WD   = 12,
    parameter int unsigned HP_WD    = 6,
    parameter int unsigned NCYC_WD  = 4,
    parameter int unsigned DAMP_CYC = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               tx_trig,
    input  logic [ADDR_WD-1:0] line_idx,
    input  logic [HP_WD-1:0]   half_per,
    input  logic [NCYC_WD-1:0] num_cyc,
    input  logic [ADDR_WD-1:0] lut_addr,
    input  logic               lut_we,
    input  logic [DLY_WD-1:0]  lut_din,
    output logic               tx_p,
    output logic               tx_n,
    output logic               tx_clamp,
    output logic               tx_en,
    output logic               busy,
    output logic               done,
    output logic               trig_miss
);

    localparam int unsigned DAMP_WD   = $clog2(DAMP_CYC + 1);
    localparam int unsigned CNT_A     = (DLY_WD > HP_WD) ? DLY_WD : HP_WD;
    localparam int unsigned CNT_WD    = (CNT_A > DAMP_WD) ? CNT_A : DAMP_WD;
    localparam int unsigned LUT_DEPTH = 1 << ADDR_WD;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_DELAY   = 3'd2,
        S_PULSE_P = 3'd3,
        S_PULSE_N = 3'd4,
`ifdef TX_DAMP_EN
        S_DAMP    = 3'd5,
`endif
        S_FIN     = 3'd6
    } state_t;

    // State entered once the burst (or an empty burst) is over
`ifdef TX_DAMP_EN
    localparam state_t S_POST = S_DAMP;
`else
    localparam state_t S_POST = S_FIN;
`endif

    state_t               state;
    state_t               next_state;
    logic [CNT_WD-1:0]    cnt;
    logic [HP_WD-1:0]     hp_q;
    logic [NCYC_WD-1:0]   ncyc_q;
    logic [HP_WD-1:0]     h_eff;
    logic                 cnt_last;
    logic                 trig_accept;
    logic [DLY_WD-1:0]    lut_mem [LUT_DEPTH];
    logic [DLY_WD-1:0]    lut_q;

    logic                 tx_p_d;
    logic                 tx_n_d;
    logic                 tx_en_d;
    logic                 done_d;
    logic                 trig_miss_d;

    assign h_eff       = (hp_q == '0) ? HP_WD'(1) : hp_q;
    assign cnt_last    = (cnt <= CNT_WD'(1));
    assign trig_accept = (state == S_IDLE) && tx_trig;

    // Delay LUT write port; contents are not reset
    always_ff @(posedge clk) begin
        if (lut_we) begin
            lut_mem[lut_addr] <= lut_din;
        end
    end

    // Delay LUT read port, issued with an accepted trigger (old data on same-address write)
    always_ff @(posedge clk) begin
        if (trig_accept) begin
            lut_q <= lut_mem[line_idx];
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (tx_trig) begin
                    next_state = S_LOAD;
                end
            end
            S_LOAD: begin
                if (lut_q != '0) begin
                    next_state = S_DELAY;
                end else if (ncyc_q == '0) begin
                    next_state = S_POST;
                end else begin
                    next_state = S_PULSE_P;
                end
            end
            S_DELAY: begin
                if (cnt_last) begin
                    next_state = (ncyc_q == '0) ? S_POST : S_PULSE_P;
                end
            end
            S_PULSE_P: begin
                if (cnt_last) begin
                    next_state = S_PULSE_N;
                end
            end
            S_PULSE_N: begin
                if (cnt_last) begin
                    next_state = (ncyc_q > NCYC_WD'(1)) ? S_PULSE_P : S_POST;
                end
            end
`ifdef TX_DAMP_EN
            S_DAMP: begin
                if (cnt_last) begin
                    next_state = S_FIN;
                end
            end
`endif
            S_FIN: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Sampled configuration and the shared delay/half-period/clamp counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt    <= '0;
            hp_q   <= '0;
            ncyc_q <= '0;
        end else begin
            if (trig_accept) begin
                hp_q   <= half_per;
                ncyc_q <= num_cyc;
            end else if ((state == S_PULSE_N) && (next_state == S_PULSE_P)) begin
                ncyc_q <= ncyc_q - NCYC_WD'(1);
            end

            if (next_state != state) begin
                case (next_state)
                    S_DELAY:              cnt <= CNT_WD'(lut_q);
                    S_PULSE_P, S_PULSE_N: cnt <= CNT_WD'(h_eff);
`ifdef TX_DAMP_EN
                    S_DAMP:               cnt <= CNT_WD'(DAMP_CYC);
`endif
                    default:              cnt <= '0;
                endcase
            end else if (cnt != '0) begin
                cnt <= cnt - CNT_WD'(1);
            end
        end
    end

    // Output decode from next state so registered outputs line up with the state
    always_comb begin
        tx_p_d      = 1'b0;
        tx_n_d      = 1'b0;
        tx_en_d     = 1'b0;
        done_d      = 1'b0;
        trig_miss_d = 1'b0;
        tx_p_d      = (next_state == S_PULSE_P);
        tx_n_d      = (next_state == S_PULSE_N);
        tx_en_d     = (next_state != S_IDLE);
        done_d      = (next_state == S_FIN);
        trig_miss_d = tx_trig && (state != S_IDLE);
    end

    // Output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_p      <= 1'b0;
            tx_n      <= 1'b0;
            tx_en     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            trig_miss <= 1'b0;
        end else begin
            tx_p      <= tx_p_d;
            tx_n      <= tx_n_d;
            tx_en     <= tx_en_d;
            busy      <= tx_en_d;
            done      <= done_d;
            trig_miss <= trig_miss_d;
        end
    end

`ifdef TX_DAMP_EN
    // Clamp drive, high only while damping after the last negative half
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_clamp <= 1'b0;
        end else begin
            tx_clamp <= (next_state == S_DAMP);
        end
    end
`else
    assign tx_clamp = 1'b0;
`endif

endmodule
